syn_lb_xtn_router: RTL and testbench
====================================

// Module: syn_lb_xtn_router
// PURPOSE
//  Sits directly downstream of the LB CDC bridge in the lb_clk_ir domain and decodes each LB transaction to one of N slave blocks.
//  Routes the slave's response back to the bridge as a registered rd/wr valid pulse.
//  A watchdog answers any transaction the slave does not answer, so the bridge never stalls.
// PARAMETERS
//  P_LB_ADDR_W    16           LB word address width
//  P_LB_DATA_W    32           LB data width
//  P_NUM_SLAVES   4            number of slave ports (<= 2**P_BLK_SEL_W)
//  P_BLK_SEL_W    2            MS address bits used as block select
//  P_TMO_W        8            timeout counter width
//  P_TMO_CYCLES   8'd200       cycles in WAIT before forced response (>=2)
//  P_ERR_RD_DATA  32'hDEAD_BEEF read data returned on timeout/unmapped
// PORTS
//  lb_clk_ir       in   1                LB clock
//  lb_rst_il       in   1                async active-low reset
//  lb_rd_en_ih     in   1                read request pulse from bridge
//  lb_wr_en_ih     in   1                write request pulse from bridge
//  lb_addr_id      in   P_LB_ADDR_W      request address
//  lb_wr_data_id   in   P_LB_DATA_W      write data
//  lb_rd_valid_oh  out  1                read response pulse to bridge
//  lb_rd_data_od   out  P_LB_DATA_W      read response data
//  lb_wr_valid_oh  out  1                write ack pulse to bridge
//  sl_rd_en_oh     out  P_NUM_SLAVES     one-hot read enable per slave
//  sl_wr_en_oh     out  P_NUM_SLAVES     one-hot write enable per slave
//  sl_addr_od      out  P_LB_ADDR_W-P_BLK_SEL_W  shared local address
//  sl_wr_data_od   out  P_LB_DATA_W      shared write data
//  sl_rd_valid_ih  in   P_NUM_SLAVES     per-slave read valid
//  sl_rd_data_id   in   P_NUM_SLAVES*P_LB_DATA_W  per-slave read data, slave i at [i*W +: W]
//  sl_wr_valid_ih  in   P_NUM_SLAVES     per-slave write ack
//  tmo_sticky_oh   out  1                set on any timeout/unmapped; cleared only by reset
//  err_cnt_od      out  8                saturating count of timeouts+unmapped+protocol errors
// BEHAVIOUR
//  - Reset: every output is 0, FSM is IDLE, and all counters are 0.
//  - sel = lb_addr_id[P_LB_ADDR_W-1 -: P_BLK_SEL_W]. Latch sel, local addr, wr data and rd/wr type on accept.
//  - FSM IDLE: rd_en|wr_en accepted. Mapped (sel<P_NUM_SLAVES) -> ISSUE; unmapped -> RESP with error.
//  - ISSUE (1 cycle): drive sl_*_en_oh[sel] for exactly one cycle, load tmo counter = 0 -> WAIT.
//  - WAIT: read waits for sl_rd_valid_ih[sel] only; write waits for sl_wr_valid_ih[sel] only.
//    Valids from other slaves, or of the wrong type, are ignored.
//    Matching valid -> capture sl_rd_data[sel] -> RESP. Counter reaches P_TMO_CYCLES -> RESP with error.
//    A matching valid in the expiry cycle wins: normal response, no error.
//  - RESP (1 cycle): pulse lb_rd_valid_oh or lb_wr_valid_oh for one cycle -> IDLE.
//    Error read returns P_ERR_RD_DATA; error write is still acked.
//    lb_rd_data_od holds its last value outside the pulse.
//  - Latency: en sampled at T0 -> sl_en at T1; slave valid at Tk -> lb valid at Tk+1.
//    Unmapped: lb valid at T1. Earliest next accept is the cycle after the RESP cycle.
//  - rd_en and wr_en in the same cycle -> treated as read, counted as a protocol error.
//  - rd_en/wr_en while not IDLE -> dropped, counted as a protocol error.
//  - Slave valid arriving in IDLE/ISSUE (late response after timeout) -> ignored.
//  - Error events: tmo_sticky_oh is set by timeouts and unmapped accesses only.
//    err_cnt_od increments once per timeout, unmapped access or protocol error and saturates at 8'hFF.
//  - Async reset mid-transaction returns to IDLE immediately with no response pulse.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE/ISSUE/WAIT/RESP), P_ERR_RD_DATA, LB width constants.
//  - Sub-module syn_lb_tmo_wdog: load/enable counter with expiry compare; rest of the block is flat.
// TESTING
//  - Write addr 16'h4010 data 32'h1234_5678, slave1 acks 3 cycles later.
//    -> sl_wr_en_oh=4'b0010, sl_addr_od=14'h0010, one lb_wr_valid_oh pulse.
//  - Read addr 16'hC004, slave3 returns 32'hCAFE_F00D.
//    -> lb_rd_data_od=32'hCAFE_F00D with a one-cycle lb_rd_valid_oh.
//  - P_NUM_SLAVES=3, read addr 16'hC000 -> no sl_en; at T1 rd_valid with 32'hDEAD_BEEF; sticky=1; err_cnt=1.
//  - Read to slave0 never answered -> rd_valid with 32'hDEAD_BEEF after P_TMO_CYCLES; a late slave0 valid is ignored.
//  - slave2 raises rd_valid while slave0 read is pending -> ignored; slave0 valid then completes the read normally.
//  - Second rd_en during WAIT -> dropped, err_cnt+1. rd_en&wr_en together -> read issued, err_cnt+1.
//    Reset asserted in WAIT -> all outputs 0.

Source files
------------

// File: rtl/syn_lb_xtn_router_pkg.sv
// Shared definitions for the LB transaction router: FSM encoding,
// default LB widths and the read data returned on error responses.
package syn_lb_xtn_router_pkg;

    // IDLE must encode as 0 so the debug state output is 0 in reset.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int          LB_ADDR_W   = 16;
    localparam int          LB_DATA_W   = 32;
    localparam logic [31:0] ERR_RD_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/syn_lb_tmo_wdog.sv
// Response watchdog: the counter is cleared by load_i and advances on
// every en_i cycle. expired_o fires in the P_TMO_CYCLES-th consecutive
// enabled cycle, so the owner spends exactly P_TMO_CYCLES cycles waiting.
module syn_lb_tmo_wdog #(
    parameter int                 P_TMO_W      = 8,
    parameter logic [P_TMO_W-1:0] P_TMO_CYCLES = 8'd200
) (
    input  logic lb_clk_ir,
    input  logic lb_rst_il,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [P_TMO_W-1:0] LAST_CNT = P_TMO_CYCLES - 1'b1;

    logic [P_TMO_W-1:0] cnt_q;
    logic [P_TMO_W-1:0] cnt_d;

    // Next count: clear on load, otherwise count up and park at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST_CNT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge lb_clk_ir or negedge lb_rst_il) begin
        if (!lb_rst_il) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/syn_lb_xtn_router.sv
// LB transaction router. Decodes each bridge request onto one of
// P_NUM_SLAVES slave ports, waits for the matching slave response and
// returns it to the bridge as a one-cycle registered valid pulse. A
// watchdog forces an error response so the bridge is always answered.
//
// Handshake: the bridge issues single-cycle rd/wr enable pulses and
// expects exactly one single-cycle valid pulse back per accepted request;
// there is no backpressure, so requests seen outside IDLE are dropped.
module syn_lb_xtn_router
    import syn_lb_xtn_router_pkg::*;
#(
    parameter int                     P_LB_ADDR_W   = LB_ADDR_W,
    parameter int                     P_LB_DATA_W   = LB_DATA_W,
    parameter int                     P_NUM_SLAVES  = 4,
    parameter int                     P_BLK_SEL_W   = 2,
    parameter int                     P_TMO_W       = 8,
    parameter logic [P_TMO_W-1:0]     P_TMO_CYCLES  = 8'd200,
    parameter logic [P_LB_DATA_W-1:0] P_ERR_RD_DATA = ERR_RD_DATA
) (
    input  logic                                 lb_clk_ir,
    input  logic                                 lb_rst_il,
    input  logic                                 lb_rd_en_ih,
    input  logic                                 lb_wr_en_ih,
    input  logic [P_LB_ADDR_W-1:0]               lb_addr_id,
    input  logic [P_LB_DATA_W-1:0]               lb_wr_data_id,
    output logic                                 lb_rd_valid_oh,
    output logic [P_LB_DATA_W-1:0]               lb_rd_data_od,
    output logic                                 lb_wr_valid_oh,
    output logic [P_NUM_SLAVES-1:0]              sl_rd_en_oh,
    output logic [P_NUM_SLAVES-1:0]              sl_wr_en_oh,
    output logic [P_LB_ADDR_W-P_BLK_SEL_W-1:0]   sl_addr_od,
    output logic [P_LB_DATA_W-1:0]               sl_wr_data_od,
    input  logic [P_NUM_SLAVES-1:0]              sl_rd_valid_ih,
    input  logic [P_NUM_SLAVES*P_LB_DATA_W-1:0]  sl_rd_data_id,
    input  logic [P_NUM_SLAVES-1:0]              sl_wr_valid_ih,
    output logic                                 tmo_sticky_oh,
    output logic [7:0]                           err_cnt_od,
    output state_e                               dbg_state_od
);

    localparam int LOC_W  = P_LB_ADDR_W - P_BLK_SEL_W;
    localparam int SEL_N  = 1 << P_BLK_SEL_W;
    localparam int EXT_W  = SEL_N * P_LB_DATA_W;
    localparam logic [P_BLK_SEL_W:0] NUM_SL = P_NUM_SLAVES[P_BLK_SEL_W:0];

    state_e                   state_q, state_d;
    logic [P_BLK_SEL_W-1:0]   sel_q, sel_d;
    logic [LOC_W-1:0]         addr_q, addr_d;
    logic [P_LB_DATA_W-1:0]   wdata_q, wdata_d;
    logic                     is_rd_q, is_rd_d;
    logic [P_LB_DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                     sticky_q, sticky_d;
    logic [7:0]               err_cnt_q, err_cnt_d;

    logic [P_BLK_SEL_W-1:0]   sel_in;
    logic                     mapped;
    logic                     req;
    logic                     match;
    logic                     expired;
    logic                     proto_err;
    logic                     resp_err;
    logic [8:0]               err_sum;

    // Slave vectors padded to the full select range so any sel indexes safely.
    logic [SEL_N-1:0]         rd_vld_ext;
    logic [SEL_N-1:0]         wr_vld_ext;
    logic [EXT_W-1:0]         rd_data_ext;
    logic [SEL_N-1:0]         sel_oh;

    assign sel_in      = lb_addr_id[P_LB_ADDR_W-1 -: P_BLK_SEL_W];
    assign mapped      = ({1'b0, sel_in} < NUM_SL);
    assign req         = lb_rd_en_ih | lb_wr_en_ih;
    assign rd_vld_ext  = SEL_N'(sl_rd_valid_ih);
    assign wr_vld_ext  = SEL_N'(sl_wr_valid_ih);
    assign rd_data_ext = EXT_W'(sl_rd_data_id);
    assign sel_oh      = SEL_N'(1) << sel_q;
    assign match       = is_rd_q ? rd_vld_ext[sel_q] : wr_vld_ext[sel_q];

    syn_lb_tmo_wdog #(
        .P_TMO_W      (P_TMO_W),
        .P_TMO_CYCLES (P_TMO_CYCLES)
    ) u_wdog (
        .lb_clk_ir (lb_clk_ir),
        .lb_rst_il (lb_rst_il),
        .load_i    (state_q == ST_ISSUE),
        .en_i      (state_q == ST_WAIT),
        .expired_o (expired)
    );

    // Next-state, request latching, response data and error accounting.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_rd_d   = is_rd_q;
        rd_data_d = rd_data_q;
        sticky_d  = sticky_q;
        proto_err = 1'b0;
        resp_err  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    sel_d     = sel_in;
                    addr_d    = lb_addr_id[LOC_W-1:0];
                    wdata_d   = lb_wr_data_id;
                    is_rd_d   = lb_rd_en_ih;
                    proto_err = lb_rd_en_ih & lb_wr_en_ih;
                    if (mapped) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d  = ST_RESP;
                        resp_err = 1'b1;
                        if (lb_rd_en_ih) begin
                            rd_data_d = P_ERR_RD_DATA;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A matching valid in the expiry cycle takes priority.
                if (match) begin
                    state_d = ST_RESP;
                    if (is_rd_q) begin
                        rd_data_d = rd_data_ext[sel_q*P_LB_DATA_W +: P_LB_DATA_W];
                    end
                end else if (expired) begin
                    state_d  = ST_RESP;
                    resp_err = 1'b1;
                    if (is_rd_q) begin
                        rd_data_d = P_ERR_RD_DATA;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if ((state_q != ST_IDLE) && req) begin
            proto_err = 1'b1;
        end
        if (resp_err) begin
            sticky_d = 1'b1;
        end
        // Timeout/unmapped and a protocol error may land in the same cycle.
        err_sum   = {1'b0, err_cnt_q} + {8'd0, proto_err} + {8'd0, resp_err};
        err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // State and datapath registers.
    always_ff @(posedge lb_clk_ir or negedge lb_rst_il) begin
        if (!lb_rst_il) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            is_rd_q   <= 1'b0;
            rd_data_q <= '0;
            sticky_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_rd_q   <= is_rd_d;
            rd_data_q <= rd_data_d;
            sticky_q  <= sticky_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Outputs are decoded purely from registers, so they are glitch-free.
    assign sl_rd_en_oh    = ((state_q == ST_ISSUE) &&  is_rd_q) ? sel_oh[P_NUM_SLAVES-1:0] : '0;
    assign sl_wr_en_oh    = ((state_q == ST_ISSUE) && !is_rd_q) ? sel_oh[P_NUM_SLAVES-1:0] : '0;
    assign sl_addr_od     = addr_q;
    assign sl_wr_data_od  = wdata_q;
    assign lb_rd_valid_oh = (state_q == ST_RESP) &&  is_rd_q;
    assign lb_wr_valid_oh = (state_q == ST_RESP) && !is_rd_q;
    assign lb_rd_data_od  = rd_data_q;
    assign tmo_sticky_oh  = sticky_q;
    assign err_cnt_od     = err_cnt_q;
    assign dbg_state_od   = state_q;

endmodule

// File: tb/tb_syn_lb_xtn_router.sv
// Directed bench for syn_lb_xtn_router: a 4-slave instance carries most
// scenarios, a 3-slave instance covers the unmapped-select response.
module tb_syn_lb_xtn_router;
  import syn_lb_xtn_router_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-slave instance
  logic         rd_en, wr_en;
  logic [15:0]  addr;
  logic [31:0]  wdata;
  logic         rd_valid, wr_valid;
  logic [31:0]  rd_data;
  logic [3:0]   sl_rd_en, sl_wr_en, sl_rd_valid, sl_wr_valid;
  logic [13:0]  sl_addr;
  logic [31:0]  sl_wdata;
  logic [127:0] sl_rd_data;
  logic         sticky;
  logic [7:0]   err_cnt;
  state_e       dbg;

  // 3-slave instance
  logic         rd_en3, wr_en3;
  logic [15:0]  addr3;
  logic [31:0]  wdata3;
  logic         rd_valid3, wr_valid3;
  logic [31:0]  rd_data3;
  logic [2:0]   sl_rd_en3, sl_wr_en3, sl_rd_valid3, sl_wr_valid3;
  logic [13:0]  sl_addr3;
  logic [31:0]  sl_wdata3;
  logic [95:0]  sl_rd_data3;
  logic         sticky3;
  logic [7:0]   err_cnt3;
  state_e       dbg3;

  syn_lb_xtn_router dut (
    .lb_clk_ir(clk), .lb_rst_il(rst_n),
    .lb_rd_en_ih(rd_en), .lb_wr_en_ih(wr_en),
    .lb_addr_id(addr), .lb_wr_data_id(wdata),
    .lb_rd_valid_oh(rd_valid), .lb_rd_data_od(rd_data), .lb_wr_valid_oh(wr_valid),
    .sl_rd_en_oh(sl_rd_en), .sl_wr_en_oh(sl_wr_en),
    .sl_addr_od(sl_addr), .sl_wr_data_od(sl_wdata),
    .sl_rd_valid_ih(sl_rd_valid), .sl_rd_data_id(sl_rd_data), .sl_wr_valid_ih(sl_wr_valid),
    .tmo_sticky_oh(sticky), .err_cnt_od(err_cnt), .dbg_state_od(dbg)
  );

  syn_lb_xtn_router #(.P_NUM_SLAVES(3)) dut3 (
    .lb_clk_ir(clk), .lb_rst_il(rst_n),
    .lb_rd_en_ih(rd_en3), .lb_wr_en_ih(wr_en3),
    .lb_addr_id(addr3), .lb_wr_data_id(wdata3),
    .lb_rd_valid_oh(rd_valid3), .lb_rd_data_od(rd_data3), .lb_wr_valid_oh(wr_valid3),
    .sl_rd_en_oh(sl_rd_en3), .sl_wr_en_oh(sl_wr_en3),
    .sl_addr_od(sl_addr3), .sl_wr_data_od(sl_wdata3),
    .sl_rd_valid_ih(sl_rd_valid3), .sl_rd_data_id(sl_rd_data3), .sl_wr_valid_ih(sl_wr_valid3),
    .tmo_sticky_oh(sticky3), .err_cnt_od(err_cnt3), .dbg_state_od(dbg3)
  );

  // scoreboard
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_d;
  int          n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rd_en = 0; wr_en = 0; addr = '0; wdata = '0;
    sl_rd_valid = '0; sl_wr_valid = '0; sl_rd_data = '0;
    rd_en3 = 0; wr_en3 = 0; addr3 = '0; wdata3 = '0;
    sl_rd_valid3 = '0; sl_wr_valid3 = '0; sl_rd_data3 = '0;
  endtask

  task automatic pop_exp();
    if (exp_q.size() > 0) exp_d = exp_q.pop_front();
    else exp_d = 32'hXXXX_XXXX;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) tick();

    // reset state
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_sl_en", {sl_rd_en, sl_wr_en}, 0);
    chk("rst_sticky_err", {sticky, err_cnt}, 0);
    chk("rst_state", dbg, ST_IDLE);
    rst_n = 1'b1;
    tick();

    // write 16'h4010 -> slave1, ack three cycles after the enable
    wr_en = 1; addr = 16'h4010; wdata = 32'h1234_5678;
    tick();
    wr_en = 0;
    chk("wr_sl_wr_en", sl_wr_en, 4'b0010);
    chk("wr_sl_rd_en", sl_rd_en, 4'b0000);
    chk("wr_sl_addr", sl_addr, 14'h0010);
    chk("wr_sl_wdata", sl_wdata, 32'h1234_5678);
    tick();
    chk("wr_sl_en_one_cycle", sl_wr_en, 4'b0000);
    tick();
    sl_wr_valid = 4'b0010;
    tick();
    sl_wr_valid = 4'b0000;
    chk("wr_ack_pulse", {wr_valid, rd_valid}, 2'b10);
    tick();
    chk("wr_ack_end", {wr_valid, rd_valid}, 2'b00);
    chk("wr_no_err", {sticky, err_cnt}, 0);

    // read 16'hC004 -> slave3 returns CAFE_F00D
    exp_q.push_back(32'hCAFE_F00D);
    rd_en = 1; addr = 16'hC004;
    tick();
    rd_en = 0;
    chk("rd_sl_rd_en", sl_rd_en, 4'b1000);
    chk("rd_sl_addr", sl_addr, 14'h0004);
    tick();
    sl_rd_valid = 4'b1000; sl_rd_data[3*32 +: 32] = 32'hCAFE_F00D;
    tick();
    sl_rd_valid = 4'b0000; sl_rd_data = '0;
    pop_exp();
    chk("rd_valid_pulse", rd_valid, 1);
    chk("rd_data", rd_data, exp_d);
    tick();
    chk("rd_valid_end", rd_valid, 0);
    chk("rd_data_hold", rd_data, 32'hCAFE_F00D);

    // unmapped read on the 3-slave instance
    rd_en3 = 1; addr3 = 16'hC000;
    tick();
    rd_en3 = 0;
    chk("unm_no_sl_en", {sl_rd_en3, sl_wr_en3}, 0);
    chk("unm_rd_valid", rd_valid3, 1);
    chk("unm_rd_data", rd_data3, 32'hDEAD_BEEF);
    chk("unm_sticky", sticky3, 1);
    chk("unm_err_cnt", err_cnt3, 1);
    tick();
    chk("unm_valid_end", rd_valid3, 0);

    // read slave0, never answered -> forced error after 200 WAIT cycles
    rd_en = 1; addr = 16'h0000;
    tick();
    rd_en = 0;
    n = 0;
    while (rd_valid !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("tmo_latency", n, 201);
    chk("tmo_rd_data", rd_data, 32'hDEAD_BEEF);
    chk("tmo_sticky", sticky, 1);
    chk("tmo_err_cnt", err_cnt, 1);
    tick();
    sl_rd_valid = 4'b0001; sl_rd_data[31:0] = 32'h5555_AAAA;
    tick();
    sl_rd_valid = 4'b0000; sl_rd_data = '0;
    chk("late_valid_ignored", {rd_valid, wr_valid}, 0);
    chk("late_state", dbg, ST_IDLE);
    chk("late_data_hold", rd_data, 32'hDEAD_BEEF);
    chk("late_err_cnt", err_cnt, 1);

    // other-slave and wrong-type valids ignored while slave0 read pending
    rd_en = 1; addr = 16'h0008;
    tick();
    rd_en = 0;
    tick();
    sl_rd_valid = 4'b0100; sl_wr_valid = 4'b0001; sl_rd_data[2*32 +: 32] = 32'h1111_2222;
    tick();
    sl_rd_valid = 4'b0000; sl_wr_valid = 4'b0000; sl_rd_data = '0;
    chk("xslave_no_resp", {rd_valid, wr_valid}, 0);
    chk("xslave_state", dbg, ST_WAIT);
    sl_rd_valid = 4'b0001; sl_rd_data[31:0] = 32'hA5A5_5A5A;
    tick();
    sl_rd_valid = 4'b0000; sl_rd_data = '0;
    chk("xslave_rd_valid", rd_valid, 1);
    chk("xslave_rd_data", rd_data, 32'hA5A5_5A5A);
    chk("xslave_err_cnt", err_cnt, 1);
    tick();

    // second rd_en during WAIT is dropped and counted
    rd_en = 1; addr = 16'h4000;
    tick();
    rd_en = 0;
    tick();
    rd_en = 1; addr = 16'hC000;
    tick();
    rd_en = 0;
    chk("drop_err_cnt", err_cnt, 2);
    chk("drop_state", dbg, ST_WAIT);
    chk("drop_no_reissue", sl_rd_en, 4'b0000);
    sl_rd_valid = 4'b0010; sl_rd_data[1*32 +: 32] = 32'h0BAD_0001;
    tick();
    sl_rd_valid = 4'b0000; sl_rd_data = '0;
    chk("drop_rd_valid", rd_valid, 1);
    chk("drop_rd_data", rd_data, 32'h0BAD_0001);
    tick();

    // rd_en & wr_en together -> read to slave2, counted as protocol error
    rd_en = 1; wr_en = 1; addr = 16'h8020; wdata = 32'hFFFF_0000;
    tick();
    rd_en = 0; wr_en = 0;
    chk("both_sl_rd_en", sl_rd_en, 4'b0100);
    chk("both_sl_wr_en", sl_wr_en, 4'b0000);
    chk("both_err_cnt", err_cnt, 3);
    tick();
    sl_rd_valid = 4'b0100; sl_rd_data[2*32 +: 32] = 32'h7777_8888;
    tick();
    sl_rd_valid = 4'b0000; sl_rd_data = '0;
    chk("both_resp", {rd_valid, wr_valid}, 2'b10);
    chk("both_rd_data", rd_data, 32'h7777_8888);
    tick();

    // matching valid in the expiry cycle wins over the timeout
    rd_en = 1; addr = 16'hC008;
    tick();
    rd_en = 0;
    repeat (200) tick();
    chk("expiry_state", dbg, ST_WAIT);
    sl_rd_valid = 4'b1000; sl_rd_data[3*32 +: 32] = 32'h600D_0042;
    tick();
    sl_rd_valid = 4'b0000; sl_rd_data = '0;
    chk("expiry_rd_valid", rd_valid, 1);
    chk("expiry_rd_data", rd_data, 32'h600D_0042);
    chk("expiry_err_cnt", err_cnt, 3);
    tick();

    // async reset while in WAIT
    wr_en = 1; addr = 16'h0030; wdata = 32'hABCD_0123;
    tick();
    wr_en = 0;
    tick();
    chk("prerst_state", dbg, ST_WAIT);
    rst_n = 1'b0;
    #1;
    chk("arst_state", dbg, ST_IDLE);
    chk("arst_valids", {rd_valid, wr_valid}, 0);
    chk("arst_outs", {sl_rd_en, sl_wr_en, sl_addr, sl_wdata}, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_err", {sticky, err_cnt}, 0);
    tick();
    rst_n = 1'b1;
    sl_wr_valid = 4'b0001;
    tick();
    sl_wr_valid = 4'b0000;
    chk("postrst_no_resp", {rd_valid, wr_valid}, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
